spi_debug_tx: RTL and testbench
===============================

# spi_debug_tx

Write-only serial transmitter inside the user project that drives the character debug stream on mprj_io[24] (SCLK) and mprj_io[25] (MOSI). The core's console/MMIO path pushes bytes through a valid/ready handshake into a small FIFO. The block shifts each byte out MSB-first, and the external receiver samples MOSI on the SCLK rising edge. There is no chip select and no receive path.

## Interface
- CLK_DIV, 2: SCLK half-period in clk cycles; legal values ≥1.
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of two, ≥2.
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- IN_valid  in  1  byte offered on IN_data.
- IN_data  in  8  byte to transmit.
- OUT_ready  out  1  FIFO not full; a byte is accepted on any cycle with IN_valid & OUT_ready.
- OUT_sclk  out  1  serial clock to mprj_io[24]; idles low.
- OUT_mosi  out  1  serial data to mprj_io[25]; changes only while OUT_sclk is low.
- OUT_busy  out  1  FIFO non-empty or shifter active.

## Operation
- FIFO: read/write pointers plus a count of $clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- OUT_ready = (count != FIFO_DEPTH), decoded from registered count. A push and a pop in the same cycle leave count unchanged.
- Shifter FSM, states IDLE and SHIFT. Internal state is an 8-bit shift register, a 3-bit bit counter, a divider counter 0..CLK_DIV-1, and a phase flag (low/high).
- IDLE -> SHIFT when the FIFO is non-empty:
  - pop the head into the shift register;
  - set the bit counter to 7 and the phase to low;
  - drive OUT_mosi = bit7.
- In SHIFT, each time the divider reaches CLK_DIV-1 it clears and the phase toggles:
  - low -> high: OUT_sclk rises. The bit is held.
  - high -> low: OUT_sclk falls. If the bit counter > 0, shift left, decrement the counter, and drive the next bit.
- At the falling edge after bit 0:
  - if the FIFO is non-empty, pop the next byte in that same cycle and drive its bit7. There is no gap between bytes.
  - otherwise, go to IDLE and drive OUT_mosi = 0.
- A byte pushed into an empty FIFO while IDLE may be popped the very next cycle. No bypass path; the data always passes through the FIFO.
- Offered bytes with OUT_ready low are not accepted. The upstream must hold IN_valid/IN_data until accepted.
- OUT_busy = (count != 0) | (state == SHIFT).

## Timing
- Reset values: OUT_sclk=0, OUT_mosi=0, OUT_ready=1, OUT_busy=0. FIFO empty, state IDLE, all counters 0.
- Reset mid-transfer:
  - OUT_sclk and OUT_mosi are 0 from the first cycle after the rst edge;
  - the partial byte and all FIFO contents are discarded;
  - no further SCLK edges occur until a new push.
- Latency: byte accepted at edge T. It is popped at T+1, and OUT_mosi shows bit7 from T+1. The first OUT_sclk rise is at T+1+CLK_DIV.
- Per byte: exactly 8 rising edges, spaced 2·CLK_DIV cycles apart. Byte length is 16·CLK_DIV cycles.
- OUT_mosi is stable for CLK_DIV cycles before and after each rising edge.
- CLK_DIV=1: SCLK toggles every cycle (clk/2). Requirements are otherwise unchanged.
- OUT_ready deasserts on the cycle after the push that fills the FIFO. It reasserts on the cycle after the next pop.

## Test plan
- Single byte: CLK_DIV=2, push 0xA5 while idle -> OUT_mosi at the 8 SCLK rises is 1,0,1,0,0,1,0,1; rises are 4 cycles apart; first rise 3 cycles after the accept edge; then IDLE with OUT_busy=0 and OUT_mosi=0.
- Back-to-back: push "Hi\n" (0x48, 0x69, 0x0A) on consecutive cycles -> 24 rises at uniform 4-cycle spacing; bit-level decode yields 0x48, 0x69, 0x0A in order.
- Backpressure: FIFO_DEPTH=4, hold IN_valid with 6 distinct bytes -> OUT_ready drops after 5 accepts (1 in the shifter, 4 queued); all 6 bytes are emitted in order with none dropped or duplicated.
- Pointer wrap: stream 20 bytes 0x00..0x13 with IN_valid asserted randomly -> the output sequence matches exactly.
- Reset mid-byte: assert rst after the 3rd rise of 0xFF with 2 bytes queued -> OUT_sclk=0, OUT_mosi=0, OUT_ready=1, OUT_busy=0 from the next cycle; no further rises; a later push of 0x55 transmits cleanly.
- CLK_DIV=1: push 0x81 -> rises every 2 cycles, bits 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/spi_debug_tx.sv
// spi_debug_tx: write-only serial transmitter for the character debug stream.
// Bytes enter a small FIFO through a valid/ready handshake and are shifted
// out MSB-first on OUT_mosi. The receiver samples OUT_mosi on the rising edge
// of OUT_sclk. Back-to-back bytes are sent with no gap between them.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | FIFO empty, OUT_sclk low, OUT_mosi low
// SHIFT | a byte is in the shift register; SCLK toggles every CLK_DIV clk
module spi_debug_tx #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       IN_valid,
    input  logic [7:0] IN_data,
    output logic       OUT_ready,
    output logic       OUT_sclk,
    output logic       OUT_mosi,
    output logic       OUT_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // A CLK_DIV of 1 still needs a one-bit divider so the compare stays legal.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_shift;
    logic [2:0]       r_bitcnt;
    logic [DIV_W-1:0] r_div;
    logic             r_phase;

    state_t           w_state_nxt;
    logic [7:0]       w_shift_nxt;
    logic [2:0]       w_bitcnt_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_phase_nxt;
    logic             w_pop;
    logic             w_push;
    logic             w_fifo_ne;
    logic [7:0]       w_head;

    assign w_push    = IN_valid & OUT_ready;
    assign w_fifo_ne = (r_count != '0);
    assign w_head    = r_mem[r_rptr];

    assign OUT_ready = (r_count != CNT_FULL);
    assign OUT_sclk  = r_phase;
    // The shift register is cleared whenever the shifter idles, so its MSB
    // doubles as the data line and is low whenever nothing is being sent.
    assign OUT_mosi  = r_shift[7];
    assign OUT_busy  = w_fifo_ne | (r_state == SHIFT);

    // FIFO storage; pointer reset is enough to discard the contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= IN_data;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Shifter state register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_div    <= '0;
            r_phase  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_div    <= w_div_nxt;
            r_phase  <= w_phase_nxt;
        end
    end

    // Next-state logic: load from the FIFO, pace SCLK, shift on falling edges.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_div_nxt    = r_div;
        w_phase_nxt  = r_phase;
        w_pop        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_fifo_ne) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_head;
                    w_bitcnt_nxt = 3'd7;
                    w_div_nxt    = '0;
                    w_phase_nxt  = 1'b0;
                    w_state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                if (r_div == DIV_MAX) begin
                    w_div_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = 1'b0;
                        if (r_bitcnt != 3'd0) begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_bitcnt_nxt = r_bitcnt - 3'd1;
                        end else if (w_fifo_ne) begin
                            // Chain straight into the next byte: no idle gap.
                            w_pop        = 1'b1;
                            w_shift_nxt  = w_head;
                            w_bitcnt_nxt = 3'd7;
                        end else begin
                            w_shift_nxt = '0;
                            w_state_nxt = IDLE;
                        end
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_spi_debug_tx.sv
// Self-checking bench for spi_debug_tx: two instances (CLK_DIV=2 and 1),
// a bit-level SCLK/MOSI monitor per instance, and a reference model that
// expects every accepted byte to appear MSB-first with fixed rise timing.
module tb_spi_debug_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst0, v0, rdy0, sclk0, mosi0, busy0;
    logic [7:0] d0;
    logic       rst1, v1, rdy1, sclk1, mosi1, busy1;
    logic [7:0] d1;

    spi_debug_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst0), .IN_valid(v0), .IN_data(d0),
        .OUT_ready(rdy0), .OUT_sclk(sclk0), .OUT_mosi(mosi0), .OUT_busy(busy0)
    );

    spi_debug_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst1), .IN_valid(v1), .IN_data(d1),
        .OUT_ready(rdy1), .OUT_sclk(sclk1), .OUT_mosi(mosi1), .OUT_busy(busy1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bit-level monitors: record every SCLK rise and the MOSI value it samples.
    int   rise_q0[$];
    logic bit_q0[$];
    int   rise_q1[$];
    logic bit_q1[$];
    logic ps0 = 1'b0, pm0 = 1'b0, ps1 = 1'b0, pm1 = 1'b0;

    // Monitor for the CLK_DIV=2 instance; MOSI must not move while SCLK is high.
    always @(negedge clk) begin
        if (sclk0 && !ps0) begin
            rise_q0.push_back(cyc);
            bit_q0.push_back(mosi0);
        end
        if (sclk0) check("mosi_hold0", {31'd0, mosi0}, {31'd0, pm0});
        ps0 = sclk0;
        pm0 = mosi0;
    end

    // Monitor for the CLK_DIV=1 instance.
    always @(negedge clk) begin
        if (sclk1 && !ps1) begin
            rise_q1.push_back(cyc);
            bit_q1.push_back(mosi1);
        end
        if (sclk1) check("mosi_hold1", {31'd0, mosi1}, {31'd0, pm1});
        ps1 = sclk1;
        pm1 = mosi1;
    end

    logic [7:0] exp_q[$];

    task automatic clear_mon(input int which);
        if (which == 0) begin
            rise_q0.delete(); bit_q0.delete();
        end else begin
            rise_q1.delete(); bit_q1.delete();
        end
        exp_q.delete();
    endtask

    // Offer one byte and hold it until accepted; returns the accept edge number.
    task automatic push(input int which, input logic [7:0] b, output int t_acc);
        logic acc;
        int   guard = 0;
        if (which == 0) begin v0 = 1'b1; d0 = b; end
        else            begin v1 = 1'b1; d1 = b; end
        do begin
            acc   = (which == 0) ? rdy0 : rdy1;
            t_acc = cyc + 1;
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 500);
        if (!acc) check("push_timeout", {31'd0, acc}, 32'd1);
        exp_q.push_back(b);
    endtask

    task automatic release_valid(input int which);
        if (which == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic wait_idle(input int which, input int budget, input string tag);
        int n = 0;
        while (((which == 0) ? busy0 : busy1) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {31'd0, (which == 0) ? busy0 : busy1}, 32'd0);
    endtask

    // Reference: each expected byte appears as 8 rises MSB-first, rises
    // 2*div apart inside a byte (and across bytes when contiguous), first
    // rise div cycles after the pop that follows the accept edge.
    task automatic verify(input string tag, input int which, input int div,
                          input bit contiguous, input int t_first);
        int   rq[$];
        logic bq[$];
        int   nb;
        if (which == 0) begin rq = rise_q0; bq = bit_q0; end
        else            begin rq = rise_q1; bq = bit_q1; end
        check({tag, "_nrises"}, rq.size(), exp_q.size() * 8);
        nb = (bq.size() / 8 < exp_q.size()) ? bq.size() / 8 : exp_q.size();
        for (int k = 0; k < nb; k++) begin
            logic [7:0] b = '0;
            for (int i = 0; i < 8; i++) b = {b[6:0], bq[8*k+i]};
            check($sformatf("%s_byte%0d", tag, k), {24'd0, b}, {24'd0, exp_q[k]});
        end
        for (int j = 1; j < rq.size(); j++) begin
            if (contiguous || (j % 8) != 0)
                check($sformatf("%s_spacing%0d", tag, j), rq[j] - rq[j-1], 2 * div);
        end
        if (t_first >= 0 && rq.size() > 0)
            check({tag, "_first_rise"}, rq[0], t_first + 1 + div);
    endtask

    logic [7:0] bp_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    initial begin
        int t, t2, stall, i, guard, nr;
        logic acc;
        rst0 = 1'b1; v0 = 1'b0; d0 = '0;
        rst1 = 1'b1; v1 = 1'b0; d1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", {31'd0, sclk0}, 32'd0);
        check("rst_mosi", {31'd0, mosi0}, 32'd0);
        check("rst_ready", {31'd0, rdy0}, 32'd1);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_ready1", {31'd0, rdy1}, 32'd1);
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;

        // Single byte while idle.
        clear_mon(0);
        push(0, 8'hA5, t);
        release_valid(0);
        @(posedge clk); #1;
        check("bit7_at_pop", {31'd0, mosi0}, 32'd1);
        wait_idle(0, 200, "single_idle");
        verify("single", 0, 2, 1'b1, t);
        check("single_mosi_after", {31'd0, mosi0}, 32'd0);
        check("single_sclk_after", {31'd0, sclk0}, 32'd0);

        // Back-to-back "Hi\n".
        clear_mon(0);
        push(0, 8'h48, t);
        push(0, 8'h69, t2);
        push(0, 8'h0A, t2);
        release_valid(0);
        wait_idle(0, 400, "b2b_idle");
        verify("b2b", 0, 2, 1'b1, t);

        // Backpressure with IN_valid held across 6 distinct bytes.
        clear_mon(0);
        v0 = 1'b1; stall = -1; i = 0; guard = 0;
        while (i < 6 && guard < 1000) begin
            d0  = bp_bytes[i];
            acc = rdy0;
            if (!acc && stall < 0) stall = i;
            @(posedge clk); #1;
            if (acc) begin exp_q.push_back(bp_bytes[i]); i++; end
            guard++;
        end
        v0 = 1'b0;
        check("bp_accepts_before_stall", stall, 5);
        wait_idle(0, 1000, "bp_idle");
        verify("bp", 0, 2, 1'b1, -1);

        // Pointer wrap: 20 bytes with random gaps.
        clear_mon(0);
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 40)) begin
                v0 = 1'b0; @(posedge clk); #1;
            end
            push(0, 8'(k), t2);
        end
        release_valid(0);
        wait_idle(0, 3000, "wrap_idle");
        verify("wrap", 0, 2, 1'b0, -1);

        // Random payload with random gaps.
        clear_mon(0);
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 20)) begin
                v0 = 1'b0; @(posedge clk); #1;
            end
            push(0, 8'($urandom), t2);
        end
        release_valid(0);
        wait_idle(0, 2000, "rand0_idle");
        verify("rand0", 0, 2, 1'b0, -1);

        // Reset in the middle of 0xFF with two bytes queued.
        clear_mon(0);
        push(0, 8'hFF, t);
        push(0, 8'h12, t2);
        push(0, 8'h34, t2);
        release_valid(0);
        guard = 0;
        while (rise_q0.size() < 3 && guard < 200) begin
            @(negedge clk); guard++;
        end
        check("mid_three_rises", rise_q0.size(), 3);
        #1 rst0 = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_sclk", {31'd0, sclk0}, 32'd0);
        check("mid_rst_mosi", {31'd0, mosi0}, 32'd0);
        check("mid_rst_ready", {31'd0, rdy0}, 32'd1);
        check("mid_rst_busy", {31'd0, busy0}, 32'd0);
        rst0 = 1'b0;
        nr = rise_q0.size();
        repeat (60) @(posedge clk);
        #1;
        check("mid_no_rises", rise_q0.size(), nr);
        check("mid_busy_after", {31'd0, busy0}, 32'd0);
        clear_mon(0);
        push(0, 8'h55, t);
        release_valid(0);
        wait_idle(0, 200, "post_rst_idle");
        verify("post_rst", 0, 2, 1'b1, t);

        // CLK_DIV=1 instance.
        clear_mon(1);
        push(1, 8'h81, t);
        release_valid(1);
        wait_idle(1, 200, "div1_idle");
        verify("div1", 1, 1, 1'b1, t);

        clear_mon(1);
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 10)) begin
                v1 = 1'b0; @(posedge clk); #1;
            end
            push(1, 8'($urandom), t2);
        end
        release_valid(1);
        wait_idle(1, 1000, "rand1_idle");
        verify("rand1", 1, 1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
